pipeline_barrier: RTL and testbench
===================================

Name: pipeline_barrier

Overview:
- Parametrised, elastic pipeline register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); replaces the fixed-width, always-advancing barriers.
- Carries a data bus and a control bus under a valid/ready handshake, with a 2-entry skid so `inReady` is purely registered.
- Supports synchronous flush (bubble insertion) and exposes saturating stall/bubble performance counters.

Parameters:
- DATA_WIDTH, 64, width of the payload bus (e.g. ALU result concatenated with memory write data).
- CTRL_WIDTH, 3, width of the control bus (e.g. memWrite, memToReg, regWrite); forced to zero whenever the output is not valid.
- COUNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  drop all held entries this cycle.
- inValid  input  1  upstream has a beat.
- inReady  output  1  barrier can accept a beat; registered.
- inData  input  DATA_WIDTH  upstream payload.
- inCtrl  input  CTRL_WIDTH  upstream control bits.
- outValid  output  1  barrier presents a beat.
- outReady  input  1  downstream accepts the beat.
- outData  output  DATA_WIDTH  presented payload.
- outCtrl  output  CTRL_WIDTH  presented control; 0 when outValid=0.
- stallCount  output  COUNT_WIDTH  cycles with outValid=1 and outReady=0.
- bubbleCount  output  COUNT_WIDTH  cycles with outValid=0 and outReady=1.

Behaviour:
- Reset (sync, active-high; clk and reset are the only clock and reset): mainValid=skidValid=0, all data/ctrl registers=0, counters=0, inReady=1, outValid=0, outData=0, outCtrl=0.
- Storage: main register (drives outputs) and skid register. Occupancy states: EMPTY (0 entries), ONE (main only), FULL (main and skid).
- Handshake events: acc = inValid & inReady; pop = outValid & outReady.
- inReady = !skidValid (registered); deasserts only in FULL.
- EMPTY: acc -> ONE; the beat is loaded into main. Latency is 1 cycle from acceptance to outValid.
- ONE:
  - acc & pop -> ONE; main is loaded with the new beat.
  - acc & !pop -> FULL; the beat goes to skid.
  - !acc & pop -> EMPTY.
  - otherwise ONE, main held.
- FULL: acc is impossible. pop -> ONE with skid moved to main; otherwise hold.
- Ordering is strictly FIFO. No beat is dropped or duplicated except by flush or reset.
- outValid = mainValid. outData = main data, which holds its last value when invalid. outCtrl = mainValid ? main ctrl : 0.
- Flush: next state is EMPTY and both ctrl registers are cleared.
  - A beat offered in the same cycle is not accepted, even though inReady may be 1; upstream must treat the flush cycle as discarding its beat.
  - A pop in the flush cycle completes normally: downstream sees that beat.
- Reset overrides flush.
- Counters:
  - Evaluated on current-cycle outputs; increment by 1; saturate at 2^COUNT_WIDTH-1 (no wrap).
  - Not cleared by flush; cleared only by reset.
  - Do not count during the reset cycle.
- Reset mid-transfer: every held beat is discarded; the next cycle is EMPTY with inReady=1.

Decomposition:
- Shared package pipeline_pkg holds:
  - the default widths (DATA_WIDTH, CTRL_WIDTH, COUNT_WIDTH);
  - the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - per-stage ctrl bit-index constants (e.g. EX_MEM_MEMWRITE=0, MEMTOREG=1, REGWRITE=2).
- One natural sub-module, sat_counter (parameter WIDTH; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Reset then idle, outReady=1 -> outValid=0, inReady=1, outCtrl=0; bubbleCount increments by 1 per cycle (5 after 5 cycles).
- Back-to-back stream, outReady=1, inData=1,2,3,4 on consecutive cycles -> outData=1,2,3,4, each one cycle later; inReady stays 1; stallCount=0.
- Backpressure: push 0xA then 0xB with outReady=0 -> FULL, inReady=0 and stallCount increments each held cycle. Then raise outReady -> 0xA then 0xB emerge in order, and inReady=1 returns one cycle after the first pop.
- Flush in FULL while inValid=1 with inData=0xC, inCtrl=3'b111:
  - next cycle outValid=0, outCtrl=0, inReady=1;
  - 0xC never appears;
  - counters are unchanged by the flush.
- Saturation with COUNT_WIDTH=4: hold outValid=1, outReady=0 for 20 cycles -> stallCount stops at 15.
- Reset asserted with flush=1 in the FULL state -> all outputs at reset values next cycle, counters=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic pipeline barrier: default widths,
// occupancy state encoding and per-stage control bit positions.
package pipeline_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 64;
  localparam int DEFAULT_CTRL_WIDTH  = 3;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  // Number of entries held by the barrier.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Control bit positions on the EX/MEM control bus.
  localparam int EX_MEM_MEMWRITE = 0;
  localparam int EX_MEM_MEMTOREG = 1;
  localparam int EX_MEM_REGWRITE = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the barrier's stall and bubble statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Count events, sticking at the all-ones value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_barrier.sv
// Elastic pipeline register with a two-entry skid buffer. The upstream
// ready is a flop output so no combinational path crosses the stage.
module pipeline_barrier
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CTRL_WIDTH  = DEFAULT_CTRL_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [DATA_WIDTH-1:0]  inData,
  input  logic [CTRL_WIDTH-1:0]  inCtrl,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [DATA_WIDTH-1:0]  outData,
  output logic [CTRL_WIDTH-1:0]  outCtrl,
  output logic [COUNT_WIDTH-1:0] stallCount,
  output logic [COUNT_WIDTH-1:0] bubbleCount
);

  occ_e                  state;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  acc;
  logic                  pop;

  // Handshake events for this cycle; a flushed beat is never accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    acc = 1'b0;
    pop = 1'b0;
    acc = inValid && in_ready && !flush;
    pop = main_valid && outReady;
  end

  // Occupancy FSM: moves beats between input, skid and main registers.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      // NOTE: payload registers are reset only because outData must read zero after reset; a pure datapath would skip this.
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // Drop everything held; a pop this cycle has already been seen downstream.
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data  <= inData;
            main_ctrl  <= inCtrl;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_data <= inData;
            main_ctrl <= inCtrl;
          end else if (acc) begin
            skid_data  <= inData;
            skid_ctrl  <= inCtrl;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign inReady  = in_ready;
  assign outValid = main_valid;
  assign outData  = main_data;
  assign outCtrl  = main_valid ? main_ctrl : '0;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (main_valid && !outReady),
    .count (stallCount)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_bubble_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (!main_valid && outReady),
    .count (bubbleCount)
  );

endmodule

// File: tb/tb_pipeline_barrier.sv
// Self-checking bench for pipeline_barrier: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_pipeline_barrier;

  localparam int DW = 64;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [CW-1:0] outCtrl;
  logic [NW-1:0] stallCount;
  logic [NW-1:0] bubbleCount;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_bubble = 0;

  pipeline_barrier #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .inValid     (inValid),
    .inReady     (inReady),
    .inData      (inData),
    .inCtrl      (inCtrl),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outCtrl     (outCtrl),
    .stallCount  (stallCount),
    .bubbleCount (bubbleCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic rdy, input logic fl);
    inValid  = v;
    inData   = d;
    inCtrl   = c;
    outReady = rdy;
    flush    = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %0b want 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %0b want 1", inReady); end
    checks++; if (outCtrl !== 3'd0) begin errors++; $display("FAIL reset_outCtrl got %0d want 0", outCtrl); end
    checks++; if (outData !== 64'd0) begin errors++; $display("FAIL reset_outData got %0h want 0", outData); end
    checks++; if (bubbleCount !== 4'd0) begin errors++; $display("FAIL reset_bubble got %0d want 0", bubbleCount); end
    for (int i = 0; i < 5; i++) tick();
    exp_bubble = 5;
    checks++; if (bubbleCount !== NW'(exp_bubble)) begin errors++; $display("FAIL idle_bubble got %0d want %0d", bubbleCount, exp_bubble); end
    checks++; if (stallCount !== 4'd0) begin errors++; $display("FAIL idle_stall got %0d want 0", stallCount); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
      tick();
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %0b want 1", i, outValid); end
      checks++; if (outData !== DW'(i)) begin errors++; $display("FAIL b2b_data got %0h want %0h", outData, i); end
      checks++; if (outCtrl !== CW'(i)) begin errors++; $display("FAIL b2b_ctrl got %0d want %0d", outCtrl, i); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady beat %0d got %0b want 1", i, inReady); end
    end
    exp_bubble++;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", outValid); end
    checks++; if (stallCount !== NW'(exp_stall)) begin errors++; $display("FAIL b2b_stall got %0d want %0d", stallCount, exp_stall); end
    checks++; if (bubbleCount !== NW'(exp_bubble)) begin errors++; $display("FAIL b2b_bubble got %0d want %0d", bubbleCount, exp_bubble); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 64'hA, 3'd1, 1'b0, 1'b0);
    tick();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL bp_one_ready got %0b want 1", inReady); end
    drive(1'b1, 64'hB, 3'd2, 1'b0, 1'b0);
    tick();
    exp_stall++;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", inReady); end
    checks++; if (outData !== 64'hA) begin errors++; $display("FAIL bp_full_data got %0h want a", outData); end
    checks++; if (stallCount !== NW'(exp_stall)) begin errors++; $display("FAIL bp_stall1 got %0d want %0d", stallCount, exp_stall); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_stall++;
      checks++; if (stallCount !== NW'(exp_stall)) begin errors++; $display("FAIL bp_stall_hold got %0d want %0d", stallCount, exp_stall); end
    end
    outReady = 1'b1;
    tick();
    checks++; if (outData !== 64'hB || outCtrl !== 3'd2) begin errors++; $display("FAIL bp_second got %0h/%0d want b/2", outData, outCtrl); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", inReady); end
    tick();
    checks++; if (outValid !== 1'b0 || outData !== 64'hB) begin errors++; $display("FAIL bp_drain got v=%0b d=%0h want v=0 d=b", outValid, outData); end
    checks++; if (stallCount !== NW'(exp_stall)) begin errors++; $display("FAIL bp_stall_end got %0d want %0d", stallCount, exp_stall); end
    outReady = 1'b0;
  endtask

  task automatic test_flush();
    drive(1'b1, 64'h11, 3'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h22, 3'd6, 1'b0, 1'b0);
    tick();
    exp_stall++;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL fl_full got %0b want 0", inReady); end
    // Flush with a pop in the same cycle: neither counter moves.
    drive(1'b1, 64'hC, 3'b111, 1'b1, 1'b1);
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", outValid); end
    checks++; if (outCtrl !== 3'd0) begin errors++; $display("FAIL fl_ctrl got %0d want 0", outCtrl); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL fl_ready got %0b want 1", inReady); end
    checks++; if (outData !== 64'h11) begin errors++; $display("FAIL fl_data_hold got %0h want 11", outData); end
    checks++; if (stallCount !== NW'(exp_stall) || bubbleCount !== NW'(exp_bubble)) begin
      errors++; $display("FAIL fl_counters got %0d/%0d want %0d/%0d", stallCount, bubbleCount, exp_stall, exp_bubble);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_bubble++;
      checks++; if (outValid !== 1'b0 || outData === 64'hC) begin errors++; $display("FAIL fl_ghost got v=%0b d=%0h want v=0", outValid, outData); end
    end
    checks++; if (bubbleCount !== NW'(exp_bubble)) begin errors++; $display("FAIL fl_bubble got %0d want %0d", bubbleCount, exp_bubble); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 64'h5A5A, 3'd4, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stallCount !== NW'(SAT)) begin errors++; $display("FAIL sat_stall got %0d want %0d", stallCount, SAT); end
    checks++; if (outData !== 64'h5A5A) begin errors++; $display("FAIL sat_data got %0h want 5a5a", outData); end
    outReady = 1'b1;
    tick();
  endtask

  task automatic test_reset_over_flush();
    drive(1'b1, 64'h33, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h44, 3'd4, 1'b0, 1'b0);
    tick();
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL rf_full got %0b want 0", inReady); end
    reset = 1'b1;
    drive(1'b1, 64'h55, 3'd7, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL rf_hs got v=%0b r=%0b want 0/1", outValid, inReady); end
    checks++; if (outData !== 64'd0 || outCtrl !== 3'd0) begin errors++; $display("FAIL rf_bus got %0h/%0d want 0/0", outData, outCtrl); end
    checks++; if (stallCount !== 4'd0 || bubbleCount !== 4'd0) begin errors++; $display("FAIL rf_cnt got %0d/%0d want 0/0", stallCount, bubbleCount); end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  task automatic test_random();
    beat_t         q[$];
    beat_t         b;
    logic [DW-1:0] last_data;
    int            m_stall;
    int            m_bubble;
    logic          acc;
    logic          pop;
    // Start from a known reset state so the model and DUT agree.
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    q.delete();
    last_data = '0;
    m_stall   = 0;
    m_bubble  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, {$urandom, $urandom}, CW'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      checks++; if (outValid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, outValid, q.size() > 0); end
      checks++; if (inReady !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, inReady, q.size() < 2); end
      checks++; if (outData !== ((q.size() > 0) ? q[0].d : last_data)) begin errors++; $display("FAIL rnd_data cyc %0d got %0h", cyc, outData); end
      checks++; if (outCtrl !== ((q.size() > 0) ? q[0].c : 3'd0)) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %0d", cyc, outCtrl); end
      checks++; if (stallCount !== NW'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", cyc, stallCount, m_stall); end
      checks++; if (bubbleCount !== NW'(m_bubble)) begin errors++; $display("FAIL rnd_bubble cyc %0d got %0d want %0d", cyc, bubbleCount, m_bubble); end
      acc = inValid && (q.size() < 2) && !flush;
      pop = (q.size() > 0) && outReady;
      if (reset) begin
        q.delete();
        last_data = '0;
        m_stall   = 0;
        m_bubble  = 0;
      end else begin
        if ((q.size() > 0) && !outReady && m_stall < SAT) m_stall++;
        if ((q.size() == 0) && outReady && m_bubble < SAT) m_bubble++;
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) begin
          b.d = inData;
          b.c = inCtrl;
          q.push_back(b);
        end
        if (q.size() > 0) last_data = q[0].d;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_over_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
